branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/branch_hist_table.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RISC-V branch definitions: funct3 encodings of the conditional
// branches, the 2-bit predictor counter type with its reset value, and the
// saturating counter update used by the branch history table.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    // Weakly not-taken: the state every predictor entry starts from.
    localparam bht_cnt_t BHT_WNT = 2'b01;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic tk);
        bht_cnt_t nxt;
        if (tk) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_hist_table.sv
// branch_hist_table
// Array of 2-bit saturating predictor counters.
// Ports:
//   clk, reset          clock, asynchronous active-high reset (entries -> 01)
//   fetchIdx/fetchCnt   combinational read port used by fetch
//   resIdx/resCnt       combinational read port used by branch resolve
//   wrEn/wrIdx/wrData   synchronous write port
// Reads return the stored value, so a write on the same edge is seen by a
// reader only after that edge (read-before-write).
module branch_hist_table
    import riscv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] fetchIdx,
    output logic [1:0]       fetchCnt,
    input  logic [IDX_W-1:0] resIdx,
    output logic [1:0]       resCnt,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [1:0]       wrData
);

    bht_cnt_t cnt_r [DEPTH];

    // Counter storage: all entries return to weakly not-taken on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_r[i] <= BHT_WNT;
            end
        end else if (wrEn) begin
            cnt_r[wrIdx] <= wrData;
        end
    end

    assign fetchCnt = cnt_r[fetchIdx];
    assign resCnt   = cnt_r[resIdx];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves RISC-V conditional branches in one cycle, trains a bimodal
// predictor and keeps saturating branch / mispredict statistics.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valid_i, flush             op present / kill this op
//   funct3, in_A, in_B, pc     branch encoding, operands and its PC
//   fetch_pc, fetch_pred       combinational predictor lookup for fetch
//   res_valid, BrEq, BrLT,     registered result (latency 1)
//   taken, mispredict, illegal
//   n_branch, n_mispred        saturating statistics counters
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  in_A,
    input  logic [XLEN-1:0]  in_B,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred,
    output logic             res_valid,
    output logic             BrEq,
    output logic             BrLT,
    output logic             taken,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] n_branch,
    output logic [CNT_W-1:0] n_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] res_idx_s;
    logic [IDX_W-1:0] fetch_idx_s;
    logic [1:0]       fetch_cnt_s;
    logic [1:0]       res_cnt_s;
    logic [1:0]       wr_cnt_s;
    logic             eq_s;
    logic             lt_s;
    logic             taken_s;
    logic             legal_s;
    logic             accept_s;
    logic             upd_s;
    logic             mispred_s;
    logic             unused_s;

    // Word-aligned PCs: drop the two byte-offset bits before indexing.
    assign res_idx_s   = pc[IDX_W+1:2];
    assign fetch_idx_s = fetch_pc[IDX_W+1:2];
    assign unused_s    = ^{pc[1:0], pc[XLEN-1:IDX_W+2],
                           fetch_pc[1:0], fetch_pc[XLEN-1:IDX_W+2], fetch_cnt_s[0]};

    branch_hist_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .fetchIdx (fetch_idx_s),
        .fetchCnt (fetch_cnt_s),
        .resIdx   (res_idx_s),
        .resCnt   (res_cnt_s),
        .wrEn     (upd_s),
        .wrIdx    (res_idx_s),
        .wrData   (wr_cnt_s)
    );

    assign fetch_pred = fetch_cnt_s[1];

    // Compare and branch-condition decode; funct3[1] selects unsigned.
    always_comb begin
        eq_s = (in_A == in_B);
        if (funct3[1]) begin
            lt_s = (in_A < in_B);
        end else begin
            lt_s = ($signed(in_A) < $signed(in_B));
        end
        case (funct3)
            F3_BEQ:  begin taken_s = eq_s;  legal_s = 1'b1; end
            F3_BNE:  begin taken_s = !eq_s; legal_s = 1'b1; end
            F3_BLT:  begin taken_s = lt_s;  legal_s = 1'b1; end
            F3_BGE:  begin taken_s = !lt_s; legal_s = 1'b1; end
            F3_BLTU: begin taken_s = lt_s;  legal_s = 1'b1; end
            F3_BGEU: begin taken_s = !lt_s; legal_s = 1'b1; end
            default: begin taken_s = 1'b0;  legal_s = 1'b0; end
        endcase
    end

    // Prediction is the pre-update counter MSB for this branch's entry.
    assign accept_s  = valid_i & ~flush;
    assign upd_s     = accept_s & legal_s;
    assign mispred_s = legal_s & (taken_s ^ res_cnt_s[1]);
    assign wr_cnt_s  = bht_next(res_cnt_s, taken_s);

    // Result register: flags load only for accepted ops, valid tracks acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            BrEq       <= 1'b0;
            BrLT       <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            res_valid <= accept_s;
            if (accept_s) begin
                BrEq       <= eq_s;
                BrLT       <= lt_s;
                taken      <= taken_s;
                mispredict <= mispred_s;
                illegal    <= ~legal_s;
            end
        end
    end

    // Statistics: count trained ops and their mispredicts, holding at max.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_branch  <= {CNT_W{1'b0}};
            n_mispred <= {CNT_W{1'b0}};
        end else begin
            if (upd_s && (n_branch != CNT_MAX)) begin
                n_branch <= n_branch + CNT_ONE;
            end
            if (upd_s && mispred_s && (n_mispred != CNT_MAX)) begin
                n_mispred <= n_mispred + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Directed and randomized stimulus for branch_resolve_unit, checked against
// a behavioural model (per-entry counters as integers, plain compares).
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] in_A = 32'h0;
    logic [31:0] in_B = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] fetch_pc = 32'h0;
    logic        fetch_pred;
    logic        res_valid;
    logic        BrEq;
    logic        BrLT;
    logic        taken;
    logic        mispredict;
    logic        illegal;
    logic [15:0] n_branch;
    logic [15:0] n_mispred;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_bht [16];
    int m_nbr;
    int m_nmis;
    logic e_eq, e_lt, e_tk, e_mis, e_ill;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush(flush),
        .funct3(funct3), .in_A(in_A), .in_B(in_B), .pc(pc),
        .fetch_pc(fetch_pc), .fetch_pred(fetch_pred), .res_valid(res_valid),
        .BrEq(BrEq), .BrLT(BrLT), .taken(taken), .mispredict(mispredict),
        .illegal(illegal), .n_branch(n_branch), .n_mispred(n_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_nbr = 0; m_nmis = 0;
        e_eq = 1'b0; e_lt = 1'b0; e_tk = 1'b0; e_mis = 1'b0; e_ill = 1'b0;
    endtask

    task automatic chk_outputs(input string tag, input logic exp_rv);
        chk({tag, "_rv"},   {31'h0, res_valid},  {31'h0, exp_rv});
        chk({tag, "_eq"},   {31'h0, BrEq},       {31'h0, e_eq});
        chk({tag, "_lt"},   {31'h0, BrLT},       {31'h0, e_lt});
        chk({tag, "_tk"},   {31'h0, taken},      {31'h0, e_tk});
        chk({tag, "_mis"},  {31'h0, mispredict}, {31'h0, e_mis});
        chk({tag, "_ill"},  {31'h0, illegal},    {31'h0, e_ill});
        chk({tag, "_nbr"},  {16'h0, n_branch},   m_nbr);
        chk({tag, "_nmis"}, {16'h0, n_mispred},  m_nmis);
    endtask

    // One op: drive at negedge, check fetch prediction before the edge,
    // check the registered result just after the edge.
    task automatic step(input logic v, input logic fl, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] fp, input string tag);
        int idx, fidx;
        logic lg, eq, lt, tk, pr;
        @(negedge clk);
        valid_i = v; flush = fl; funct3 = f3; in_A = a; in_B = b; pc = p; fetch_pc = fp;
        idx  = (p >> 2) % 16;
        fidx = (fp >> 2) % 16;
        #1;
        chk({tag, "_fpred"}, {31'h0, fetch_pred}, (m_bht[fidx] >= 2) ? 32'd1 : 32'd0);
        eq = (a == b);
        lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        lg = 1'b1;
        case (f3)
            3'b000: tk = eq;
            3'b001: tk = !eq;
            3'b100, 3'b110: tk = lt;
            3'b101, 3'b111: tk = !lt;
            default: begin tk = 1'b0; lg = 1'b0; end
        endcase
        pr = (m_bht[idx] >= 2);
        @(posedge clk);
        #1;
        if (v && !fl) begin
            e_eq = eq; e_lt = lt; e_tk = tk; e_ill = !lg;
            e_mis = lg && (tk != pr);
            if (lg) begin
                if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
                if (m_nbr < 65535) m_nbr++;
                if (e_mis && m_nmis < 65535) m_nmis++;
            end
        end
        chk_outputs(tag, v && !fl);
    endtask

    initial begin
        logic [31:0] ra, rb, rp, rf;
        logic [2:0]  rf3;
        int nbr_before;
        model_reset();

        // Reset held: all outputs zero
        @(negedge clk);
        @(negedge clk);
        chk_outputs("in_reset", 1'b0);
        reset = 1'b0;
        fetch_pc = 32'h0;
        #1;
        chk("rel_fpred", {31'h0, fetch_pred}, 32'd0);
        chk_outputs("after_rel", 1'b0);

        // Four taken BEQ at 0x40, then a not-taken one
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h40, 32'h0, "beq_tk");
            chk("beq_mis_dir", {31'h0, mispredict}, (i == 0) ? 32'd1 : 32'd0);
        end
        chk("beq_sat", {30'h0, dut.u_bht.cnt_r[0]}, 32'd3);
        step(1'b1, 1'b0, 3'b000, 32'd5, 32'd6, 32'h40, 32'h0, "beq_nt");
        chk("beq_nt_mis", {31'h0, mispredict}, 32'd1);
        chk("beq_nt_entry", {30'h0, dut.u_bht.cnt_r[0]}, 32'd2);
        chk("beq_nmis_dir", {16'h0, n_mispred}, 32'd2);

        // Signed vs unsigned compare of -5 and 5
        step(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFB, 32'd5, 32'h104, 32'h0, "blt");
        chk("blt_lt_dir", {31'h0, BrLT}, 32'd1);
        chk("blt_tk_dir", {31'h0, taken}, 32'd1);
        step(1'b1, 1'b0, 3'b110, 32'hFFFF_FFFB, 32'd5, 32'h108, 32'h0, "bltu");
        chk("bltu_tk_dir", {31'h0, taken}, 32'd0);

        // Illegal funct3: result valid, nothing trained
        nbr_before = m_nbr;
        step(1'b1, 1'b0, 3'b010, 32'd1, 32'd1, 32'h40, 32'h0, "ill");
        chk("ill_dir", {31'h0, illegal}, 32'd1);
        chk("ill_nbr_dir", {16'h0, n_branch}, nbr_before);
        chk("ill_entry", {30'h0, dut.u_bht.cnt_r[0]}, 32'd2);
        step(1'b1, 1'b0, 3'b011, 32'd1, 32'd2, 32'h40, 32'h0, "ill3");

        // Flushed op with same-entry fetch lookup
        step(1'b1, 1'b1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h40, "flush");
        chk("flush_entry", {30'h0, dut.u_bht.cnt_r[0]}, 32'd2);

        // Read-before-write: fetch sees 2 in the update cycle, 1 after
        step(1'b1, 1'b0, 3'b001, 32'd7, 32'd7, 32'h40, 32'h40, "rbw");
        chk("rbw_after", {31'h0, fetch_pred}, 32'd0);

        // Randomized back-to-back traffic over a small PC window
        for (int i = 0; i < 300; i++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) rb = ~ra;
            rf3 = 3'($urandom_range(0, 7));
            rp  = 32'h1000 + 32'($urandom_range(0, 15) << 2);
            rf  = 32'h2000 + 32'($urandom_range(0, 15) << 2);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rf3, ra, rb, rp, rf, "rnd");
        end

        // Asynchronous reset clears a registered result without a clock edge
        step(1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 32'h40, 32'h40, "pre_rst");
        #1;
        reset = 1'b1;
        #1;
        chk("arst_rv", {31'h0, res_valid}, 32'd0);
        chk("arst_nbr", {16'h0, n_branch}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("arst_bht", {30'h0, dut.u_bht.cnt_r[i]}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Reset between issue and the result edge
        @(negedge clk);
        valid_i = 1'b1; flush = 1'b0; funct3 = 3'b000; in_A = 32'd3; in_B = 32'd3; pc = 32'h44;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rv", {31'h0, res_valid}, 32'd0);
        chk("mid_rst_entry", {30'h0, dut.u_bht.cnt_r[1]}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        valid_i = 1'b0;
        step(1'b1, 1'b0, 3'b101, 32'd2, 32'd9, 32'h44, 32'h44, "post_rst");
        step(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'h44, 32'h44, "idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
